// File: rtl/axis_frame_len_arb.sv
// rtl/axis_frame_len_arb.sv - round-robin serialiser of per-port frame length events onto one stream
// Optional per-port saturating drop counters: define AXIS_FRAME_LEN_ARB_DROP_CNT_EN.
module axis_frame_len_arb #(
   parameter int PORTS          = 4,
   parameter int LEN_WIDTH      = 16,
   parameter int DROP_CNT_WIDTH = 16,
   localparam int ID_WIDTH      = $clog2(PORTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS*LEN_WIDTH-1:0]    in_frame_len,
   input  logic [PORTS-1:0]              in_frame_len_valid,
   output logic [LEN_WIDTH-1:0]          m_axis_tdata,
   output logic [ID_WIDTH-1:0]           m_axis_tid,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [PORTS*DROP_CNT_WIDTH-1:0] drop_count
);

   typedef enum logic {IDLE, VALID} state_t;

   state_t                 state_q, state_d;
   logic [PORTS-1:0]       pend_q;
   logic [LEN_WIDTH-1:0]   len_q [PORTS];
   logic [ID_WIDTH-1:0]    rr_q;
   logic [LEN_WIDTH-1:0]   tdata_q;
   logic [ID_WIDTH-1:0]    tid_q;

   logic                   gnt_any;
   logic [ID_WIDTH-1:0]    gnt_idx;
   logic                   out_free;
   logic                   grant_en;
   logic [PORTS-1:0]       gnt_onehot;
   logic [PORTS-1:0]       load;

   // First pending slot after the last winner, wrapping modulo PORTS.
   always_comb begin : rr_search
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= PORTS; k++) begin
         idx = (int'(rr_q) + k) % PORTS;
         if (!gnt_any && pend_q[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      out_free = 1'b0;
      case (state_q)
         IDLE:    out_free = 1'b1;
         VALID:   out_free = m_axis_tready;
         default: out_free = 1'b1;
      endcase
      if (out_free)
         state_d = gnt_any ? VALID : IDLE;
      grant_en   = out_free && gnt_any;
      gnt_onehot = grant_en ? (PORTS'(1) << gnt_idx) : '0;
   end

   // A slot being granted this cycle is free to take a new event at the same edge.
   assign load = in_frame_len_valid & (~pend_q | gnt_onehot);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         rr_q    <= '0;
         tdata_q <= '0;
         tid_q   <= '0;
         for (int p = 0; p < PORTS; p++)
            len_q[p] <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= (pend_q & ~gnt_onehot) | load;
         if (grant_en) begin
            tdata_q <= len_q[gnt_idx];
            tid_q   <= gnt_idx;
            rr_q    <= gnt_idx;
         end
         for (int p = 0; p < PORTS; p++)
            if (load[p])
               len_q[p] <= in_frame_len[p*LEN_WIDTH +: LEN_WIDTH];
      end
   end

   assign m_axis_tvalid = (state_q == VALID);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tid    = tid_q;

`ifdef AXIS_FRAME_LEN_ARB_DROP_CNT_EN
   logic [PORTS-1:0]          drop;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q [PORTS];

   assign drop = in_frame_len_valid & pend_q & ~gnt_onehot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PORTS; p++)
            drop_cnt_q[p] <= '0;
      end else begin
         for (int p = 0; p < PORTS; p++)
            if (drop[p] && (drop_cnt_q[p] != '1))
               drop_cnt_q[p] <= drop_cnt_q[p] + DROP_CNT_WIDTH'(1);
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_drop_out
      assign drop_count[p*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt_q[p];
   end
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len_arb.sv
// tb/tb_axis_frame_len_arb.sv - directed bench for axis_frame_len_arb with a cycle model and literal checks
module tb_axis_frame_len_arb;

   localparam int PORTS = 4;
   localparam int LW    = 16;
   localparam int DW    = 4;
   localparam int IW    = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [PORTS*LW-1:0]   in_frame_len = '0;
   logic [PORTS-1:0]      in_frame_len_valid = '0;
   logic [LW-1:0]         m_axis_tdata;
   logic [IW-1:0]         m_axis_tid;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready = 1'b1;
   logic [PORTS*DW-1:0]   drop_count;

   axis_frame_len_arb #(.PORTS(PORTS), .LEN_WIDTH(LW), .DROP_CNT_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_frame_len(in_frame_len), .in_frame_len_valid(in_frame_len_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one holding slot per port, a one-beat output, round-robin pick.
   int  m_len  [PORTS];
   bit  m_pend [PORTS];
   int  m_drop [PORTS];
   int  m_rr = 0, m_data = 0, m_id = 0;
   bit  m_valid = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_pend[p]) begin m_pend[p] = 0; m_len[p] = 0; m_drop[p] = 0; end
         m_rr = 0; m_data = 0; m_id = 0; m_valid = 0;
      end else begin
         int win;
         win = -1;
         if (!m_valid || m_axis_tready) begin
            for (int k = 1; k <= PORTS; k++)
               if (win < 0 && m_pend[(m_rr + k) % PORTS]) win = (m_rr + k) % PORTS;
            if (win >= 0) begin
               m_data = m_len[win]; m_id = win; m_rr = win;
               m_valid = 1; m_pend[win] = 0;
            end else m_valid = 0;
         end
         for (int p = 0; p < PORTS; p++)
            if (in_frame_len_valid[p]) begin
               if (!m_pend[p]) begin
                  m_pend[p] = 1; m_len[p] = int'(in_frame_len[p*LW +: LW]);
               end else if (m_drop[p] < (1 << DW) - 1) m_drop[p]++;
            end
      end
   end

   function automatic int exp_drop(input int p);
`ifdef AXIS_FRAME_LEN_ARB_DROP_CNT_EN
      return m_drop[p];
`else
      return 0;
`endif
   endfunction

   always @(negedge clk) begin
      chk("model_tvalid", int'(m_axis_tvalid), int'(m_valid));
      chk("model_tdata", int'(m_axis_tdata), m_data);
      chk("model_tid", int'(m_axis_tid), m_id);
      for (int p = 0; p < PORTS; p++)
         chk($sformatf("model_drop%0d", p), int'(drop_count[p*DW +: DW]), exp_drop(p));
   end

   // Accepted beats, for the hand-computed sequence checks.
   int cyc = 0;
   int bq_data[$], bq_id[$], bq_cyc[$];
   always @(posedge clk) begin
      cyc++;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         bq_data.push_back(int'(m_axis_tdata));
         bq_id.push_back(int'(m_axis_tid));
         bq_cyc.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int p, input int v);
      in_frame_len[p*LW +: LW] = v[LW-1:0];
   endtask

   task automatic pulse(input logic [PORTS-1:0] mask);
      in_frame_len_valid = mask;
      tick(1);
      in_frame_len_valid = '0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      tick(2);
      rst = 1'b0;
      bq_data.delete(); bq_id.delete(); bq_cyc.delete();
   endtask

   task automatic chk_beat(input string name, input int i, input int id, input int data);
      chk({name, "_id"}, (i < bq_id.size()) ? bq_id[i] : -1, id);
      chk({name, "_data"}, (i < bq_data.size()) ? bq_data[i] : -1, data);
   endtask

   localparam int EXP_DROP3 = 1;
`ifdef AXIS_FRAME_LEN_ARB_DROP_CNT_EN
   localparam int DROP_ON = 1;
`else
   localparam int DROP_ON = 0;
`endif

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", int'(m_axis_tvalid), 0);
      chk("rst_tdata", int'(m_axis_tdata), 0);
      chk("rst_tid", int'(m_axis_tid), 0);
      chk("rst_drop", int'(drop_count), 0);
      tick(1);
      rst = 1'b0;

      // single event on port 2, two-cycle latency, one beat
      set_len(2, 'h40);
      pulse(4'b0100);
      @(negedge clk); chk("t1_lat_tvalid", int'(m_axis_tvalid), 0);
      @(negedge clk);
      chk("t1_tvalid", int'(m_axis_tvalid), 1);
      chk("t1_tdata", int'(m_axis_tdata), 'h40);
      chk("t1_tid", int'(m_axis_tid), 2);
      @(negedge clk); chk("t1_after_tvalid", int'(m_axis_tvalid), 0);
      tick(1);

      // all four ports at once from rr=0
      do_reset();
      set_len(0, 10); set_len(1, 20); set_len(2, 30); set_len(3, 40);
      pulse(4'b1111);
      tick(6);
      chk("t2_count", bq_id.size(), 4);
      chk_beat("t2_b0", 0, 1, 20);
      chk_beat("t2_b1", 1, 2, 30);
      chk_beat("t2_b2", 2, 3, 40);
      chk_beat("t2_b3", 3, 0, 10);
      chk("t2_nobubble", (bq_cyc.size() == 4) ? bq_cyc[3] - bq_cyc[0] : -1, 3);

      // backpressure: held beat, one slot load, one drop
      do_reset();
      m_axis_tready = 1'b0;
      set_len(0, 5); pulse(4'b0001);
      tick(1);
      set_len(0, 7); pulse(4'b0001);
      set_len(0, 9); pulse(4'b0001);
      @(negedge clk);
      chk("t3_tvalid", int'(m_axis_tvalid), 1);
      chk("t3_tdata", int'(m_axis_tdata), 5);
      chk("t3_tid", int'(m_axis_tid), 0);
      chk("t3_drop0", int'(drop_count[3:0]), DROP_ON);
      tick(1);
      m_axis_tready = 1'b1;
      tick(4);
      chk("t3_count", bq_id.size(), 2);
      chk_beat("t3_b0", 0, 0, 5);
      chk_beat("t3_b1", 1, 0, 7);

      // grant and reload of port 1 at the same edge
      do_reset();
      m_axis_tready = 1'b0;
      set_len(0, 1); pulse(4'b0001);
      tick(1);
      set_len(1, 3); pulse(4'b0010);
      set_len(1, 4);
      m_axis_tready = 1'b1;
      pulse(4'b0010);
      tick(4);
      chk("t4_count", bq_id.size(), 3);
      chk_beat("t4_b0", 0, 0, 1);
      chk_beat("t4_b1", 1, 1, 3);
      chk_beat("t4_b2", 2, 1, 4);
      chk("t4_drop1", int'(drop_count[7:4]), 0);

      // twenty drops on port 3 saturate a 4-bit counter
      do_reset();
      m_axis_tready = 1'b0;
      set_len(3, 'h33);
      in_frame_len_valid = 4'b1000;
      tick(22);
      in_frame_len_valid = '0;
      @(negedge clk);
      chk("t5_drop3", int'(drop_count[15:12]), DROP_ON ? 'hF : 0);
      chk("t5_drop0", int'(drop_count[3:0]), 0);
      tick(1);

      // async reset mid-burst, then rr restarts at 0
      do_reset();
      m_axis_tready = 1'b0;
      set_len(0, 1); set_len(1, 2); set_len(2, 3); set_len(3, 4);
      pulse(4'b1111);
      tick(3);
      chk("t6_pre_tvalid", int'(m_axis_tvalid), 1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_tvalid", int'(m_axis_tvalid), 0);
      chk("t6_async_tdata", int'(m_axis_tdata), 0);
      chk("t6_async_tid", int'(m_axis_tid), 0);
      tick(1);
      rst = 1'b0;
      m_axis_tready = 1'b1;
      bq_data.delete(); bq_id.delete(); bq_cyc.delete();
      set_len(0, 'h55); set_len(3, 'h66);
      pulse(4'b1001);
      tick(5);
      chk("t6_count", bq_id.size(), 2);
      chk_beat("t6_b0", 0, 3, 'h66);
      chk_beat("t6_b1", 1, 0, 'h55);
      chk("t6_drop_sum", int'(drop_count), 0 * EXP_DROP3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

endmodule
